// File: rtl/debug_scanner_if.sv
// Debug scanner bus bundle: scan request and abort, the debug read port,
// the word output stream with its handshake, and the status flags.
interface debug_scanner_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] word_cnt;
    logic             abort;
    logic [31:0]      chk_addr;
    logic [31:0]      chk_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_addr;
    logic [31:0]      out_data;
    logic             out_last;
    logic             busy;
    logic             done;

    modport slave (
        input  start, base_addr, word_cnt, abort, chk_data, out_ready,
        output chk_addr, out_valid, out_addr, out_data, out_last, busy, done
    );

    modport master (
        output start, base_addr, word_cnt, abort, chk_data, out_ready,
        input  chk_addr, out_valid, out_addr, out_data, out_last, busy, done
    );
endinterface

// File: rtl/debug_scanner.sv
// Debug scanner: walks word_cnt consecutive debug addresses from base_addr,
// waits SETTLE cycles per address for the responder, then streams each word.
module debug_scanner #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    debug_scanner_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] SEND = 2'd3;

    logic [1:0]       state_q,     state_d;
    logic [31:0]      chkAddr_q,   chkAddr_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [3:0]       waitCnt_q,   waitCnt_d;
    logic             outValid_q,  outValid_d;
    logic [31:0]      outAddr_q,   outAddr_d;
    logic [31:0]      outData_q,   outData_d;
    logic             outLast_q,   outLast_d;
    logic             done_q,      done_d;

    always_comb begin
        state_d     = state_q;
        chkAddr_d   = chkAddr_q;
        remaining_d = remaining_q;
        waitCnt_d   = waitCnt_q;
        outValid_d  = outValid_q;
        outAddr_d   = outAddr_q;
        outData_d   = outData_q;
        outLast_d   = outLast_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.word_cnt != '0) begin
                        chkAddr_d   = bus.base_addr;
                        remaining_d = bus.word_cnt;
                        state_d     = ADDR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                waitCnt_d = 4'(SETTLE);
                state_d   = WAIT;
            end
            WAIT: begin
                if (waitCnt_q <= 4'd1) begin
                    outData_d  = bus.chk_data;
                    outAddr_d  = chkAddr_q;
                    outLast_d  = (remaining_q == CNT_W'(1));
                    outValid_d = 1'b1;
                    waitCnt_d  = 4'd0;
                    state_d    = SEND;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            SEND: begin
                if (outValid_q && bus.out_ready) begin
                    outValid_d = 1'b0;
                    if (remaining_q > CNT_W'(1)) begin
                        remaining_d = remaining_q - CNT_W'(1);
                        chkAddr_d   = chkAddr_q + 32'd1;
                        state_d     = ADDR;
                    end else begin
                        outLast_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a handshake in the same cycle.
        if (state_q != IDLE && bus.abort) begin
            state_d    = IDLE;
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            chkAddr_q   <= 32'd0;
            remaining_q <= '0;
            waitCnt_q   <= 4'd0;
            outValid_q  <= 1'b0;
            outAddr_q   <= 32'd0;
            outData_q   <= 32'd0;
            outLast_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            chkAddr_q   <= chkAddr_d;
            remaining_q <= remaining_d;
            waitCnt_q   <= waitCnt_d;
            outValid_q  <= outValid_d;
            outAddr_q   <= outAddr_d;
            outData_q   <= outData_d;
            outLast_q   <= outLast_d;
            done_q      <= done_d;
        end
    end

    assign bus.chk_addr  = chkAddr_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_addr  = outAddr_q;
    assign bus.out_data  = outData_q;
    assign bus.out_last  = outLast_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_debug_scanner.sv
// Directed bench for debug_scanner with SETTLE=1 and a responder that
// returns addr ^ 0xA5A5A5A5; expected words are hand-computed constants.
module tb_debug_scanner;

    logic clk;
    logic rst;
    int   compareCount;
    int   mismatchCount;
    int   cycleNo;
    int   firstAddrCycle;

    debug_scanner_if #(.CNT_W(16)) dbg ();

    debug_scanner #(.SETTLE(1), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dbg.slave)
    );

    assign dbg.chk_data = dbg.chk_addr ^ 32'hA5A5A5A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [15:0] cnt);
        dbg.start     = 1'b1;
        dbg.base_addr = base;
        dbg.word_cnt  = cnt;
        tick();
        dbg.start     = 1'b0;
        firstAddrCycle = cycleNo;
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (dbg.out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkOutput({tag, ".valid"}, 32'(dbg.out_valid), 32'd1);
    endtask

    task automatic expectWord(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input logic last);
        waitValid(tag);
        checkOutput({tag, ".addr"}, dbg.out_addr, addr);
        checkOutput({tag, ".data"}, dbg.out_data, data);
        checkOutput({tag, ".last"}, 32'(dbg.out_last), 32'(last));
        checkOutput({tag, ".done"}, 32'(dbg.done), 32'd0);
    endtask

    task automatic quietWatch(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, ".valid"}, 32'(dbg.out_valid), 32'd0);
            checkOutput({tag, ".done"}, 32'(dbg.done), 32'd0);
            checkOutput({tag, ".busy"}, 32'(dbg.busy), 32'd0);
            tick();
        end
    endtask

    task automatic expectDone(input string tag);
        checkOutput({tag, ".done"}, 32'(dbg.done), 32'd1);
        checkOutput({tag, ".busy"}, 32'(dbg.busy), 32'd0);
        checkOutput({tag, ".valid"}, 32'(dbg.out_valid), 32'd0);
        checkOutput({tag, ".last"}, 32'(dbg.out_last), 32'd0);
        tick();
        checkOutput({tag, ".doneDrop"}, 32'(dbg.done), 32'd0);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        cycleNo       = 0;
        rst           = 1'b1;
        dbg.start     = 1'b0;
        dbg.base_addr = 32'd0;
        dbg.word_cnt  = 16'd0;
        dbg.abort     = 1'b0;
        dbg.out_ready = 1'b1;

        #3;
        checkOutput("rst.chk_addr", dbg.chk_addr, 32'd0);
        checkOutput("rst.out_valid", 32'(dbg.out_valid), 32'd0);
        checkOutput("rst.out_last", 32'(dbg.out_last), 32'd0);
        checkOutput("rst.out_addr", dbg.out_addr, 32'd0);
        checkOutput("rst.out_data", dbg.out_data, 32'd0);
        checkOutput("rst.busy", 32'(dbg.busy), 32'd0);
        checkOutput("rst.done", 32'(dbg.done), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic three-word scan with the consumer always ready.
        applyStimulus(32'h0001_0000, 16'd3);
        checkOutput("basic.busy", 32'(dbg.busy), 32'd1);
        checkOutput("basic.chk_addr", dbg.chk_addr, 32'h0001_0000);
        expectWord("basic.w0", 32'h0001_0000, 32'hA5A4_A5A5, 1'b0);
        checkOutput("basic.w0lat", 32'(cycleNo - firstAddrCycle + 1), 32'd3);
        tick();
        expectWord("basic.w1", 32'h0001_0001, 32'hA5A4_A5A4, 1'b0);
        tick();
        expectWord("basic.w2", 32'h0001_0002, 32'hA5A4_A5A7, 1'b1);
        checkOutput("basic.total", 32'(cycleNo - firstAddrCycle + 1), 32'd9);
        tick();
        expectDone("basic");

        // Backpressure: consumer stalls five cycles on the first word.
        dbg.out_ready = 1'b0;
        applyStimulus(32'h0000_0200, 16'd2);
        waitValid("bp.w0");
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp.holdValid", 32'(dbg.out_valid), 32'd1);
            checkOutput("bp.holdAddr", dbg.out_addr, 32'h0000_0200);
            checkOutput("bp.holdData", dbg.out_data, 32'hA5A5_A7A5);
            tick();
        end
        dbg.out_ready = 1'b1;
        expectWord("bp.w0", 32'h0000_0200, 32'hA5A5_A7A5, 1'b0);
        tick();
        checkOutput("bp.resumeValid", 32'(dbg.out_valid), 32'd0);
        checkOutput("bp.resumeAddr", dbg.chk_addr, 32'h0000_0201);
        checkOutput("bp.resumeBusy", 32'(dbg.busy), 32'd1);
        expectWord("bp.w1", 32'h0000_0201, 32'hA5A5_A7A4, 1'b1);
        tick();
        expectDone("bp");

        // Address wrap at the top of the 32-bit space.
        applyStimulus(32'hFFFF_FFFF, 16'd2);
        expectWord("wrap.w0", 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0);
        tick();
        expectWord("wrap.w1", 32'h0000_0000, 32'hA5A5_A5A5, 1'b1);
        tick();
        expectDone("wrap");

        // Zero-length scan only pulses done.
        applyStimulus(32'h0000_1234, 16'd0);
        checkOutput("zero.done", 32'(dbg.done), 32'd1);
        checkOutput("zero.busy", 32'(dbg.busy), 32'd0);
        checkOutput("zero.valid", 32'(dbg.out_valid), 32'd0);
        tick();
        quietWatch("zero.after", 3);

        // A second start while busy must not disturb the address sequence.
        applyStimulus(32'h0000_3000, 16'd3);
        dbg.start     = 1'b1;
        dbg.base_addr = 32'h0000_9000;
        dbg.word_cnt  = 16'd1;
        tick();
        dbg.start     = 1'b0;
        expectWord("ign.w0", 32'h0000_3000, 32'hA5A5_95A5, 1'b0);
        tick();
        expectWord("ign.w1", 32'h0000_3001, 32'hA5A5_95A4, 1'b0);
        tick();
        expectWord("ign.w2", 32'h0000_3002, 32'hA5A5_95A7, 1'b1);
        tick();
        expectDone("ign");

        // Abort in WAIT of word 2 of 4.
        applyStimulus(32'h0000_0400, 16'd4);
        expectWord("abw.w0", 32'h0000_0400, 32'hA5A5_A1A5, 1'b0);
        tick();
        tick();
        checkOutput("abw.chk_addr", dbg.chk_addr, 32'h0000_0401);
        checkOutput("abw.inWait", 32'(dbg.out_valid), 32'd0);
        dbg.abort = 1'b1;
        tick();
        dbg.abort = 1'b0;
        checkOutput("abw.last", 32'(dbg.out_last), 32'd0);
        quietWatch("abw.after", 5);

        // Abort coincident with the handshake of word 1.
        applyStimulus(32'h0000_0500, 16'd3);
        expectWord("abh.w0", 32'h0000_0500, 32'hA5A5_A0A5, 1'b0);
        dbg.abort = 1'b1;
        tick();
        dbg.abort = 1'b0;
        checkOutput("abh.last", 32'(dbg.out_last), 32'd0);
        quietWatch("abh.after", 6);

        // Abort and start together in IDLE: no scan begins.
        dbg.abort = 1'b1;
        applyStimulus(32'h0000_0800, 16'd2);
        dbg.abort = 1'b0;
        quietWatch("abs", 4);

        // Asynchronous reset asserted between clock edges during WAIT.
        applyStimulus(32'h0000_0600, 16'd2);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst.chk_addr", dbg.chk_addr, 32'd0);
        checkOutput("arst.out_valid", 32'(dbg.out_valid), 32'd0);
        checkOutput("arst.out_last", 32'(dbg.out_last), 32'd0);
        checkOutput("arst.out_addr", dbg.out_addr, 32'd0);
        checkOutput("arst.out_data", dbg.out_data, 32'd0);
        checkOutput("arst.busy", 32'(dbg.busy), 32'd0);
        checkOutput("arst.done", 32'(dbg.done), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        quietWatch("arst.after", 6);
        applyStimulus(32'h0000_0700, 16'd1);
        expectWord("arst.new", 32'h0000_0700, 32'hA5A5_A2A5, 1'b1);
        tick();
        expectDone("arst.new");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
